target_rx: RTL and testbench
============================

TARGET_RX -- requirements
Module: target_rx

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: i_sys_clk (input, 1, system clock) and i_sys_rst (input, 1, async active-low reset).
REQ-002 i_rx_en  input  1  capture enable from the target engine.
REQ-003 i_rx_mode  input  4  capture mode: 0 PREAMBLE, 1 DATA, 2 CRC; other codes reserved.
REQ-004 i_scl_pos_edge / i_scl_neg_edge  input  1 each  single-cycle SCL edge strobes, already synchronised.
REQ-005 i_sda  input  1  synchronised SDA level.
REQ-006 o_rx_dec  output  2  decode result, valid while o_rx_dec_done=1 and held until the next done.
REQ-007 o_rx_dec_done  output  1  one-cycle pulse marking a completed field.
REQ-008 o_rx_data  output  16  last received DATA word.

Function
REQ-009 Sampling SHALL be DDR: one SDA bit per strobe; if both strobes are high in one cycle, exactly one bit SHALL be sampled.
REQ-010 The FSM SHALL have the states IDLE, CAPTURE and DONE.
REQ-011 IDLE SHALL latch i_rx_mode, clear the bit counter and enter CAPTURE on any cycle with i_rx_en=1 and a valid mode.
REQ-012 With i_rx_en=1 and a reserved mode, the FSM SHALL stay in IDLE with no done pulse.
REQ-013 Field lengths SHALL be: PREAMBLE 2 bits; DATA 18 bits (D15..D0, then P1, P0); CRC 9 bits (4-bit token, then CRC5). All fields are MSB first.
REQ-014 Bits SHALL shift into a 18-bit register under control of a 5-bit counter.
REQ-015 After the last bit is sampled, the FSM SHALL enter DONE; o_rx_dec_done SHALL be high exactly that one DONE cycle, then the FSM returns to IDLE.
REQ-016 Latency SHALL be one cycle from the sampling strobe of the last bit to the done pulse.
REQ-017 PREAMBLE: o_rx_dec SHALL equal the two sampled bits {first, second}.
REQ-018 DATA: P1 SHALL equal D15^D13^...^D1, and P0 SHALL equal D14^D12^...^D0^1.
REQ-019 DATA: o_rx_dec SHALL be 2'b00 if both parity bits match, else 2'b01; o_rx_data SHALL be updated regardless of the parity result.
REQ-020 CRC5 SHALL use polynomial x^5+x^2+1 with init 5'h1F, updated over the 16 data bits of every completed DATA word in MSB-first order.
REQ-021 CRC: o_rx_dec SHALL be 2'b10 if the token is not 4'hC, 2'b11 if the token is correct but the CRC5 mismatches, and 2'b00 if both are correct.
REQ-022 The CRC accumulator SHALL re-initialise to 5'h1F after every completed CRC field.
REQ-023 i_rx_en falling during CAPTURE SHALL abort the field: return to IDLE next cycle, no done pulse, counter cleared, accumulator and o_rx_data unchanged.
REQ-024 A change of i_rx_mode during CAPTURE SHALL be ignored; only the mode latched in IDLE applies.
REQ-025 Strobes arriving in IDLE or DONE SHALL be discarded.
REQ-026 If the engine holds i_rx_en high, a new capture SHALL begin in the cycle after DONE, using the then-current mode.

Reset
REQ-027 On i_sys_rst=0, the block SHALL asynchronously set: state IDLE, counter 0, shift register 0, o_rx_dec 2'b00, o_rx_dec_done 0, o_rx_data 16'h0000, CRC accumulator 5'h1F.
REQ-028 Reset asserted mid-capture SHALL discard the partial field with no done pulse.
REQ-029 Reset deassertion SHALL need no strobe to reach IDLE.

Structure
REQ-030 A shared package target_rx_pkg SHALL hold: mode encodings, o_rx_dec codes, field lengths (2/18/9), CRC token 4'hC, polynomial 5'h05 and init 5'h1F.
REQ-031 CRC5 computation SHALL be a sub-module target_crc5: 16-bit word in, 5-bit CRC in/out, with init and update controls.
REQ-032 All FSM, counter and decode logic SHALL reside in target_rx.

Verification
REQ-033 Mode 0, SDA bits 1,0 on alternating edges -> one done pulse, o_rx_dec=2'b10, 1 cycle after the 2nd strobe.
REQ-034 Mode 1, word 16'hA5F0 with parity 2'b01 -> o_rx_data=16'hA5F0, o_rx_dec=2'b00. Same word with parity 2'b11 -> o_rx_dec=2'b01.
REQ-035 Mode 2 after data 16'hA5F0: token 4'hC plus model CRC5 -> 2'b00; token 4'hA -> 2'b10; token 4'hC with CRC bit flipped -> 2'b11; the following CRC field starts from 5'h1F.
REQ-036 Mode 1, i_rx_en dropped after 9 bits -> no done pulse. Then a full word -> correct data and parity, no residue from the aborted field.
REQ-037 i_sys_rst pulsed low after 5 DATA bits -> all outputs at reset values immediately; no done pulse until a fresh 18-bit field completes.
REQ-038 Both strobes high in one cycle, and mode 4'h7 with i_rx_en=1 -> one bit sampled per such cycle; reserved mode stays IDLE with no done pulse.

Source files
------------

// File: rtl/target_rx_pkg.sv
// -----------------------------------------------------------------------------
// target_rx_pkg
// Shared definitions for the target receive path: capture mode encodings,
// decode result codes, field lengths, CRC token and CRC5 constants, FSM state
// type and small helpers used by target_rx and target_crc5.
// -----------------------------------------------------------------------------
package target_rx_pkg;

  // Capture mode as presented on i_rx_mode; codes 3..15 are reserved.
  typedef enum logic [3:0] {
    MODE_PREAMBLE = 4'd0,
    MODE_DATA     = 4'd1,
    MODE_CRC      = 4'd2
  } rx_mode_e;

  // Decode result codes for DATA and CRC fields (PREAMBLE reports raw bits).
  localparam logic [1:0] DEC_OK         = 2'b00;
  localparam logic [1:0] DEC_PARITY_ERR = 2'b01;
  localparam logic [1:0] DEC_TOKEN_ERR  = 2'b10;
  localparam logic [1:0] DEC_CRC_ERR    = 2'b11;

  // Field lengths in bits.
  localparam logic [4:0] LEN_PREAMBLE = 5'd2;
  localparam logic [4:0] LEN_DATA     = 5'd18;
  localparam logic [4:0] LEN_CRC      = 5'd9;

  localparam logic [3:0] CRC_TOKEN  = 4'hC;
  localparam logic [4:0] CRC5_POLY  = 5'h05;  // x^5 + x^2 + 1
  localparam logic [4:0] CRC5_INIT  = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic logic mode_valid(input logic [3:0] mode);
    return (mode == MODE_PREAMBLE) || (mode == MODE_DATA) || (mode == MODE_CRC);
  endfunction

  function automatic logic [4:0] field_len(input rx_mode_e mode);
    case (mode)
      MODE_DATA: return LEN_DATA;
      MODE_CRC:  return LEN_CRC;
      default:   return LEN_PREAMBLE;
    endcase
  endfunction

endpackage

// File: rtl/target_rx_if.sv
// -----------------------------------------------------------------------------
// target_rx_if
// Bundle between the target engine (master) and the receive block (slave).
//   i_rx_en        capture enable
//   i_rx_mode      capture mode (PREAMBLE/DATA/CRC, others reserved)
//   i_scl_pos_edge synchronised SCL rising-edge strobe
//   i_scl_neg_edge synchronised SCL falling-edge strobe
//   i_sda          synchronised SDA level
//   o_rx_dec       decode result, held until the next done
//   o_rx_dec_done  one-cycle field-complete pulse
//   o_rx_data      last received DATA word
// -----------------------------------------------------------------------------
interface target_rx_if;
  logic        i_rx_en;
  logic [3:0]  i_rx_mode;
  logic        i_scl_pos_edge;
  logic        i_scl_neg_edge;
  logic        i_sda;
  logic [1:0]  o_rx_dec;
  logic        o_rx_dec_done;
  logic [15:0] o_rx_data;

  modport master (
    output i_rx_en, i_rx_mode, i_scl_pos_edge, i_scl_neg_edge, i_sda,
    input  o_rx_dec, o_rx_dec_done, o_rx_data
  );

  modport slave (
    input  i_rx_en, i_rx_mode, i_scl_pos_edge, i_scl_neg_edge, i_sda,
    output o_rx_dec, o_rx_dec_done, o_rx_data
  );
endinterface

// File: rtl/target_crc5.sv
// -----------------------------------------------------------------------------
// target_crc5
// Combinational CRC5 step (x^5 + x^2 + 1) over a 16-bit word, MSB first.
//   crc_in   current accumulator value
//   data_in  16-bit word to fold in
//   init     force output to the init value (takes priority)
//   update   output crc_in advanced over data_in
//   crc_out  next accumulator value (crc_in when neither control is set)
// -----------------------------------------------------------------------------
module target_crc5
  import target_rx_pkg::*;
(
  input  logic [4:0]  crc_in,
  input  logic [15:0] data_in,
  input  logic        init,
  input  logic        update,
  output logic [4:0]  crc_out
);

  // chain[k] is the CRC after the first k bits (D15 first).
  logic [16:0][4:0] chain;

  assign chain[0] = crc_in;

  for (genvar gi = 0; gi < 16; gi++) begin : g_bit
    logic fb;
    assign fb           = chain[gi][4] ^ data_in[15-gi];
    assign chain[gi+1]  = {chain[gi][3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
  end

  always_comb begin
    crc_out = crc_in;
    if (init) begin
      crc_out = CRC5_INIT;
    end else if (update) begin
      crc_out = chain[16];
    end
  end

endmodule

// File: rtl/target_rx.sv
// -----------------------------------------------------------------------------
// target_rx
// DDR SDA capture for PREAMBLE / DATA / CRC fields with parity and CRC5 decode.
//   i_sys_clk  system clock
//   i_sys_rst  asynchronous active-low reset
//   rx         target_rx_if.slave: enable, mode, SCL strobes, SDA in;
//              decode result, done pulse and last DATA word out
// -----------------------------------------------------------------------------
module target_rx
  import target_rx_pkg::*;
(
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  target_rx_if.slave  rx
);

  state_e      state_reg;
  rx_mode_e    mode_reg;
  logic [4:0]  cnt_reg;
  logic [17:0] shift_reg;
  logic [1:0]  dec_reg;
  logic        done_reg;
  logic [15:0] data_reg;
  logic [4:0]  crc_reg;

  logic        strobe;
  logic [17:0] shift_next;
  logic [4:0]  cnt_next;
  logic        last_bit;
  logic        field_end;
  logic [1:0]  parity_calc;
  logic [4:0]  crc_next;

  // Either edge carries one bit; coincident strobes still count once.
  assign strobe     = rx.i_scl_pos_edge | rx.i_scl_neg_edge;
  assign shift_next = {shift_reg[16:0], rx.i_sda};
  assign cnt_next   = cnt_reg + 5'd1;
  assign last_bit   = strobe && (cnt_next == field_len(mode_reg));
  assign field_end  = (state_reg == ST_CAPTURE) && rx.i_rx_en && last_bit;

  // P1 covers odd data bits, P0 even data bits with odd sense.
  assign parity_calc[1] = ^(shift_next[17:2] & 16'hAAAA);
  assign parity_calc[0] = ~^(shift_next[17:2] & 16'h5555);

  target_crc5 u_crc5 (
    .crc_in  (crc_reg),
    .data_in (shift_next[17:2]),
    .init    (field_end && (mode_reg == MODE_CRC)),
    .update  (field_end && (mode_reg == MODE_DATA)),
    .crc_out (crc_next)
  );

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_PREAMBLE;
      cnt_reg   <= 5'd0;
      shift_reg <= 18'd0;
      dec_reg   <= DEC_OK;
      done_reg  <= 1'b0;
      data_reg  <= 16'h0000;
      crc_reg   <= CRC5_INIT;
    end else begin
      done_reg <= 1'b0;
      crc_reg  <= crc_next;
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= 5'd0;
          if (rx.i_rx_en && mode_valid(rx.i_rx_mode)) begin
            mode_reg  <= rx_mode_e'(rx.i_rx_mode);
            state_reg <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!rx.i_rx_en) begin
            // Abort: partial field is dropped, accumulator/data untouched.
            cnt_reg   <= 5'd0;
            state_reg <= ST_IDLE;
          end else if (strobe) begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            if (last_bit) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              case (mode_reg)
                MODE_DATA: begin
                  data_reg <= shift_next[17:2];
                  dec_reg  <= (shift_next[1:0] == parity_calc) ? DEC_OK : DEC_PARITY_ERR;
                end
                MODE_CRC: begin
                  if (shift_next[8:5] != CRC_TOKEN) begin
                    dec_reg <= DEC_TOKEN_ERR;
                  end else if (shift_next[4:0] != crc_reg) begin
                    dec_reg <= DEC_CRC_ERR;
                  end else begin
                    dec_reg <= DEC_OK;
                  end
                end
                default: dec_reg <= shift_next[1:0];
              endcase
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rx.o_rx_dec      = dec_reg;
  assign rx.o_rx_dec_done = done_reg;
  assign rx.o_rx_data     = data_reg;

endmodule

// File: tb/tb_target_rx.sv
// -----------------------------------------------------------------------------
// tb_target_rx
// Directed vector table, hand-written abort/reset/reserved-mode sequences and
// randomized fields checked against a field-level reference model.
// -----------------------------------------------------------------------------
module tb_target_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  target_rx_if rx_if ();

  target_rx dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .rx        (rx_if)
  );

  int errors = 0;
  int checks = 0;
  bit edge_sel = 1'b0;

  // Reference model state: last DATA word and CRC accumulator.
  logic [15:0] model_data = 16'h0000;
  logic [4:0]  model_crc  = 5'h1F;

  typedef struct {
    logic [3:0]  mode;
    logic [17:0] val;
    int          n;
    bit          both;
    logic [1:0]  exp_dec;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [4:0] crc_ref(input logic [4:0] c, input logic [15:0] d);
    logic [4:0] x;
    x = c;
    for (int b = 15; b >= 0; b--) begin
      if (x[4] ^ d[b]) x = {x[3:0], 1'b0} ^ 5'h05;
      else             x = {x[3:0], 1'b0};
    end
    return x;
  endfunction

  function automatic logic [1:0] parity_ref(input logic [15:0] d);
    logic p1, p0;
    p1 = 1'b0;
    p0 = 1'b1;
    for (int b = 1; b < 16; b += 2) p1 ^= d[b];
    for (int b = 0; b < 16; b += 2) p0 ^= d[b];
    return {p1, p0};
  endfunction

  // Applies one completed field to the model; returns the expected decode.
  function automatic logic [1:0] model_apply(input logic [3:0] m, input logic [17:0] v);
    logic [1:0] r;
    r = 2'b00;
    case (m)
      4'd0: r = v[1:0];
      4'd1: begin
        r = (v[1:0] == parity_ref(v[17:2])) ? 2'b00 : 2'b01;
        model_data = v[17:2];
        model_crc  = crc_ref(model_crc, v[17:2]);
      end
      4'd2: begin
        if (v[8:5] != 4'hC)          r = 2'b10;
        else if (v[4:0] != model_crc) r = 2'b11;
        else                          r = 2'b00;
        model_crc = 5'h1F;
      end
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit both);
    rx_if.i_sda = b;
    if (both) begin
      rx_if.i_scl_pos_edge = 1'b1;
      rx_if.i_scl_neg_edge = 1'b1;
    end else begin
      rx_if.i_scl_pos_edge = edge_sel;
      rx_if.i_scl_neg_edge = ~edge_sel;
      edge_sel = ~edge_sel;
    end
    tick();
    rx_if.i_scl_pos_edge = 1'b0;
    rx_if.i_scl_neg_edge = 1'b0;
  endtask

  // Sends a full field MSB first with random gaps, then checks the done pulse.
  task automatic field(input logic [3:0] m, input logic [17:0] val, input int n,
                       input bit both, input bit keep_en,
                       input logic [1:0] exp_dec, input logic [15:0] exp_data,
                       input string tag);
    rx_if.i_rx_en   = 1'b1;
    rx_if.i_rx_mode = m;
    tick();
    for (int i = n - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk({tag, "_gap_done"}, 32'(rx_if.o_rx_dec_done), 32'd0);
      end
      send_bit(val[i], both);
      if (i == n - 1) rx_if.i_rx_mode = 4'($urandom_range(0, 15));
      if (i > 0) chk({tag, "_early_done"}, 32'(rx_if.o_rx_dec_done), 32'd0);
    end
    chk({tag, "_done"}, 32'(rx_if.o_rx_dec_done), 32'd1);
    chk({tag, "_dec"}, 32'(rx_if.o_rx_dec), 32'(exp_dec));
    chk({tag, "_data"}, 32'(rx_if.o_rx_data), 32'(exp_data));
    $display("field %s mode=%0d bits=%0d val=%05h dec=%0h data=%04h", tag, m, n, val,
             rx_if.o_rx_dec, rx_if.o_rx_data);
    if (!keep_en) rx_if.i_rx_en = 1'b0;
    // Stray strobe in the DONE cycle must be discarded.
    rx_if.i_sda          = 1'($urandom_range(0, 1));
    rx_if.i_scl_pos_edge = 1'($urandom_range(0, 1));
    tick();
    rx_if.i_scl_pos_edge = 1'b0;
    chk({tag, "_pulse_width"}, 32'(rx_if.o_rx_dec_done), 32'd0);
    chk({tag, "_dec_hold"}, 32'(rx_if.o_rx_dec), 32'(exp_dec));
  endtask

  initial begin
    logic [4:0]  crc_two, crc_one;
    logic [15:0] d;
    logic [17:0] v;
    logic [3:0]  m;
    logic [3:0]  tok;
    logic [4:0]  c;
    logic [1:0]  par, e;
    int          n;

    rx_if.i_rx_en        = 1'b0;
    rx_if.i_rx_mode      = 4'd0;
    rx_if.i_scl_pos_edge = 1'b0;
    rx_if.i_scl_neg_edge = 1'b0;
    rx_if.i_sda          = 1'b0;

    crc_two = crc_ref(crc_ref(5'h1F, 16'hA5F0), 16'hA5F0);
    crc_one = crc_ref(5'h1F, 16'hA5F0);
    vecs[0] = '{4'd0, 18'b10,                     2,  1'b0, 2'b10, 16'h0000};
    vecs[1] = '{4'd1, {16'hA5F0, 2'b01},          18, 1'b0, 2'b00, 16'hA5F0};
    vecs[2] = '{4'd1, {16'hA5F0, 2'b11},          18, 1'b0, 2'b01, 16'hA5F0};
    vecs[3] = '{4'd2, 18'({4'hC, crc_two}),       9,  1'b0, 2'b00, 16'hA5F0};
    vecs[4] = '{4'd2, 18'({4'hA, 5'h1F}),         9,  1'b0, 2'b10, 16'hA5F0};
    vecs[5] = '{4'd1, {16'hA5F0, 2'b01},          18, 1'b1, 2'b00, 16'hA5F0};
    vecs[6] = '{4'd2, 18'({4'hC, crc_one ^ 5'h01}), 9, 1'b0, 2'b11, 16'hA5F0};
    vecs[7] = '{4'd2, 18'({4'hC, 5'h1F}),         9,  1'b0, 2'b00, 16'hA5F0};
    vecs[8] = '{4'd0, 18'b01,                     2,  1'b1, 2'b01, 16'hA5F0};

    // Reset state
    #12;
    chk("reset_dec", 32'(rx_if.o_rx_dec), 32'd0);
    chk("reset_done", 32'(rx_if.o_rx_dec_done), 32'd0);
    chk("reset_data", 32'(rx_if.o_rx_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      e = model_apply(vecs[i].mode, vecs[i].val);
      field(vecs[i].mode, vecs[i].val, vecs[i].n, vecs[i].both, (i % 2) == 1,
            vecs[i].exp_dec, vecs[i].exp_data, $sformatf("vec%0d", i));
    end

    // Abort after 9 DATA bits, then a clean word
    rx_if.i_rx_en   = 1'b1;
    rx_if.i_rx_mode = 4'd1;
    tick();
    for (int i = 0; i < 9; i++) begin
      send_bit(1'($urandom_range(0, 1)), 1'b0);
      chk("abort_early_done", 32'(rx_if.o_rx_dec_done), 32'd0);
    end
    rx_if.i_rx_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(rx_if.o_rx_dec_done), 32'd0);
    end
    chk("abort_data_kept", 32'(rx_if.o_rx_data), 32'(model_data));
    $display("abort after 9 bits data=%04h", rx_if.o_rx_data);
    v = {16'h3C5A, parity_ref(16'h3C5A)};
    e = model_apply(4'd1, v);
    field(4'd1, v, 18, 1'b0, 1'b0, e, model_data, "after_abort");

    // Reserved mode with enable high: no capture, no done
    rx_if.i_rx_en   = 1'b1;
    rx_if.i_rx_mode = 4'h7;
    for (int i = 0; i < 12; i++) begin
      rx_if.i_sda          = 1'($urandom_range(0, 1));
      rx_if.i_scl_pos_edge = 1'b1;
      rx_if.i_scl_neg_edge = 1'($urandom_range(0, 1));
      tick();
      chk("reserved_no_done", 32'(rx_if.o_rx_dec_done), 32'd0);
    end
    rx_if.i_scl_pos_edge = 1'b0;
    rx_if.i_scl_neg_edge = 1'b0;
    rx_if.i_rx_en        = 1'b0;
    tick();
    $display("reserved mode 7 held 12 cycles done=%0d", rx_if.o_rx_dec_done);
    e = model_apply(4'd0, 18'b11);
    field(4'd0, 18'b11, 2, 1'b0, 1'b0, e, model_data, "after_reserved");

    // Reset pulse after 5 DATA bits
    rx_if.i_rx_en   = 1'b1;
    rx_if.i_rx_mode = 4'd1;
    tick();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dec", 32'(rx_if.o_rx_dec), 32'd0);
    chk("midrst_done", 32'(rx_if.o_rx_dec_done), 32'd0);
    chk("midrst_data", 32'(rx_if.o_rx_data), 32'd0);
    $display("reset mid-capture dec=%0h data=%04h", rx_if.o_rx_dec, rx_if.o_rx_data);
    model_data = 16'h0000;
    model_crc  = 5'h1F;
    tick();
    tick();
    rst_n = 1'b1;
    v = {16'h0F0F, parity_ref(16'h0F0F)};
    e = model_apply(4'd1, v);
    field(4'd1, v, 18, 1'b0, 1'b0, e, model_data, "after_reset");
    v = 18'({4'hC, model_crc});
    e = model_apply(4'd2, v);
    field(4'd2, v, 9, 1'b0, 1'b0, e, model_data, "crc_after_reset");

    // Randomized fields against the reference model
    for (int k = 0; k < 40; k++) begin
      m = 4'($urandom_range(0, 2));
      case (m)
        4'd0: begin
          n = 2;
          v = 18'($urandom_range(0, 3));
        end
        4'd1: begin
          n   = 18;
          d   = 16'($urandom);
          par = parity_ref(d);
          if ($urandom_range(0, 1) == 1) par ^= 2'($urandom_range(1, 3));
          v   = {d, par};
        end
        default: begin
          n   = 9;
          tok = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hC;
          c   = ($urandom_range(0, 1) == 1) ? model_crc : 5'($urandom);
          v   = 18'({tok, c});
        end
      endcase
      e = model_apply(m, v);
      field(m, v, n, 1'($urandom_range(0, 1)), (k < 39) && ($urandom_range(0, 1) == 1),
            e, model_data, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
